// File: rtl/wimax_cc_pkg.sv
// Shared constants for the WiMAX K=7 convolutional encoder with puncturing.
// Rate codes, generator polynomials and per-rate puncture patterns.
package wimax_cc_pkg;

   typedef enum logic [1:0] {
      RATE_1_2 = 2'd0,
      RATE_2_3 = 2'd1,
      RATE_3_4 = 2'd2,
      RATE_5_6 = 2'd3
   } rate_e;

   localparam int unsigned K_DEF        = 7;
   localparam int unsigned TAIL_LEN_DEF = 8;

   // Generator taps, MSB applies to the current input bit u.
   localparam logic [6:0] G1 = 7'o171;
   localparam logic [6:0] G2 = 7'o133;

   // Bit i of a mask corresponds to puncture phase i.
   function automatic logic [4:0] punct_x_mask(input rate_e r);
      case (r)
         RATE_1_2: punct_x_mask = 5'b00001;
         RATE_2_3: punct_x_mask = 5'b00001;
         RATE_3_4: punct_x_mask = 5'b00101;
         RATE_5_6: punct_x_mask = 5'b10101;
         default:  punct_x_mask = 5'b00001;
      endcase
   endfunction

   function automatic logic [4:0] punct_y_mask(input rate_e r);
      case (r)
         RATE_1_2: punct_y_mask = 5'b00001;
         RATE_2_3: punct_y_mask = 5'b00011;
         RATE_3_4: punct_y_mask = 5'b00011;
         RATE_5_6: punct_y_mask = 5'b01011;
         default:  punct_y_mask = 5'b00001;
      endcase
   endfunction

   function automatic logic [2:0] punct_period(input rate_e r);
      case (r)
         RATE_1_2: punct_period = 3'd1;
         RATE_2_3: punct_period = 3'd2;
         RATE_3_4: punct_period = 3'd3;
         RATE_5_6: punct_period = 3'd5;
         default:  punct_period = 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/cc_punct_enc_if.sv
// Bit-serial input and output handshake of the punctured convolutional encoder.
interface cc_punct_enc_if;

   logic       in_bit;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic [1:0] rate;
   logic       out_bit;
   logic       out_valid;
   logic       out_last;

   modport master (
      output in_bit, in_valid, in_last, rate,
      input  in_ready, out_bit, out_valid, out_last
   );

   modport slave (
      input  in_bit, in_valid, in_last, rate,
      output in_ready, out_bit, out_valid, out_last
   );

endinterface

// File: rtl/conv_enc_core.sv
// K=7 shift-register encoder core: combinational X/Y from {u, s0..s5}.
// clear_i makes the step see an all-zero history (start of burst).
module conv_enc_core
   import wimax_cc_pkg::*;
#(
   parameter int unsigned K = K_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear_i,
   input  logic         step_i,
   input  logic         u_i,
   output logic         x_o,
   output logic         y_o,
   output logic [K-2:0] state_o
);

   // s_q[K-2] is s0 (most recent bit), s_q[0] is the oldest.
   logic [K-2:0] s_q, s_d, s_eff;
   logic [K-1:0] d;

   always_comb begin
      s_eff = clear_i ? '0 : s_q;
      d     = {u_i, s_eff};
      x_o   = ^(d & G1[K-1:0]);
      y_o   = ^(d & G2[K-1:0]);
      s_d   = s_eff;
      if (step_i) begin
         s_d = {u_i, s_eff[K-2:1]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_q <= '0;
      end else begin
         s_q <= s_d;
      end
   end

   assign state_o = s_q;

endmodule

// File: rtl/cc_punct_enc.sv
// Bit-serial K=7 convolutional encoder with zero tail and puncturing.
// Coded bits pass through a 2-entry buffer; out_bit is registered.
module cc_punct_enc
   import wimax_cc_pkg::*;
#(
   parameter int unsigned TAIL_LEN = TAIL_LEN_DEF,
   parameter int unsigned K        = K_DEF
) (
   input  logic          clk,
   input  logic          reset,
   cc_punct_enc_if.slave bus_io
);

   localparam int unsigned TailW = $clog2(TAIL_LEN + 1);

   typedef enum logic [1:0] {StIdle, StData, StTail, StDrain} state_e;

   state_e           state_q, state_d;
   rate_e            rate_q, rate_d, rate_cur;
   logic [2:0]       phase_q, phase_d, phase_cur, phase_nxt;
   logic [TailW-1:0] tail_cnt_q, tail_cnt_d;
   logic [1:0]       pend_q, pend_d;
   logic [1:0]       buf_q, buf_d;
   logic             out_bit_q, out_bit_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;

   logic             can_step, in_ready, xfer, first, tail_step, step;
   logic             enc_u, enc_x, enc_y, keep_x, keep_y;
   logic [4:0]       xmask, ymask;
   logic [3:0]       seq;
   logic [1:0]       cnt;
   logic [K-2:0]     enc_state;

   // With at most one bit pending, a step adding two bits cannot overflow.
   assign can_step  = (pend_q <= 2'd1);
   assign in_ready  = ((state_q == StIdle) || (state_q == StData)) && can_step;
   assign xfer      = bus_io.in_valid && in_ready;
   assign first     = (state_q == StIdle) && xfer;
   assign tail_step = (state_q == StTail) && can_step;
   assign step      = xfer || tail_step;
   assign enc_u     = (state_q == StTail) ? 1'b0 : bus_io.in_bit;

   assign rate_cur  = first ? rate_e'(bus_io.rate) : rate_q;
   assign phase_cur = first ? 3'd0 : phase_q;
   assign xmask     = punct_x_mask(rate_cur);
   assign ymask     = punct_y_mask(rate_cur);
   assign keep_x    = step && xmask[phase_cur];
   assign keep_y    = step && ymask[phase_cur];

   conv_enc_core #(
      .K (K)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .clear_i (first),
      .step_i  (step),
      .u_i     (enc_u),
      .x_o     (enc_x),
      .y_o     (enc_y),
      .state_o (enc_state)
   );

   // Pending bits first, then kept X, then kept Y; seq[0] goes out this clock.
   always_comb begin
      seq = {2'b00, buf_q & {pend_q == 2'd2, pend_q != 2'd0}};
      cnt = pend_q;
      if (keep_x) begin
         seq = seq | ({3'b000, enc_x} << cnt);
         cnt = cnt + 2'd1;
      end
      if (keep_y) begin
         seq = seq | ({3'b000, enc_y} << cnt);
         cnt = cnt + 2'd1;
      end
      out_valid_d = (cnt != 2'd0);
      out_bit_d   = seq[0];
      buf_d       = seq[2:1];
      pend_d      = out_valid_d ? (cnt - 2'd1) : 2'd0;

      phase_nxt = phase_cur + 3'd1;
      phase_d   = phase_q;
      if (step) begin
         phase_d = (phase_nxt == punct_period(rate_cur)) ? 3'd0 : phase_nxt;
      end
   end

   always_comb begin
      state_d    = state_q;
      rate_d     = rate_q;
      tail_cnt_d = tail_cnt_q;
      out_last_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (xfer) begin
               rate_d     = rate_cur;
               tail_cnt_d = '0;
               state_d    = bus_io.in_last ? StTail : StData;
            end
         end
         StData: begin
            if (xfer && bus_io.in_last) begin
               tail_cnt_d = '0;
               state_d    = StTail;
            end
         end
         StTail: begin
            if (tail_step) begin
               tail_cnt_d = tail_cnt_q + TailW'(1);
               if (tail_cnt_q == TailW'(TAIL_LEN - 1)) begin
                  // Skip DRAIN when this step leaves nothing buffered.
                  if (cnt == 2'd1) begin
                     out_last_d = 1'b1;
                     state_d    = StIdle;
                  end else begin
                     state_d = StDrain;
                  end
               end
            end
         end
         StDrain: begin
            if (pend_q == 2'd1) begin
               out_last_d = 1'b1;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         rate_q      <= RATE_1_2;
         phase_q     <= '0;
         tail_cnt_q  <= '0;
         pend_q      <= '0;
         buf_q       <= '0;
         out_bit_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rate_q      <= rate_d;
         phase_q     <= phase_d;
         tail_cnt_q  <= tail_cnt_d;
         pend_q      <= pend_d;
         buf_q       <= buf_d;
         out_bit_q   <= out_bit_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   // The zero tail flushes the register, so outside a burst the history is clean.
   always_ff @(posedge clk) begin
      if (!reset && ((state_q == StDrain) || (state_q == StIdle))) begin
         assert (enc_state == '0);
      end
   end

   assign bus_io.in_ready  = in_ready;
   assign bus_io.out_bit   = out_bit_q;
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.out_last  = out_last_q;

endmodule

// File: tb/tb_cc_punct_enc.sv
// Directed-vector bench for cc_punct_enc: bursts compared against hand values
// and an independent bit-level encoder model.
module tb_cc_punct_enc;

   logic clk;
   logic reset;

   cc_punct_enc_if bus ();

   cc_punct_enc dut (
      .clk    (clk),
      .reset  (reset),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  rate;
      int          len;
      logic [31:0] data;     // bit sent i is data[len-1-i]
      int          exp_cnt;
      int          plen;
      logic [31:0] prefix;   // first output bit is prefix[plen-1]
      bit          gaps;
      bit          flip;
   } vec_t;

   vec_t vecs[7];

   int   total = 0;
   int   bad   = 0;
   bit   got[$];
   bit   exp_q[$];
   int   last_pos;
   int   ready_bad;
   int   stray_last;
   bit   last_taken;
   bit   mon_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask

   task automatic build_expected(input logic [1:0] r, input int len, input logic [31:0] data);
      logic [5:0] s;
      logic       u, x, y;
      int         ph;
      string      xs, ys;
      case (r)
         2'd0:    begin xs = "1";     ys = "1";     end
         2'd1:    begin xs = "10";    ys = "11";    end
         2'd2:    begin xs = "101";   ys = "110";   end
         default: begin xs = "10101"; ys = "11010"; end
      endcase
      exp_q.delete();
      s  = '0;
      ph = 0;
      for (int i = 0; i < len + 8; i++) begin
         u = (i < len) ? data[len-1-i] : 1'b0;
         x = u ^ s[0] ^ s[1] ^ s[2] ^ s[5];
         y = u ^ s[1] ^ s[2] ^ s[4] ^ s[5];
         if (xs[ph] == "1") exp_q.push_back(x);
         if (ys[ph] == "1") exp_q.push_back(y);
         s  = {s[4:0], u};
         ph = (ph + 1) % xs.len();
      end
   endtask

   // Called just after a posedge; returns just after the posedge taking the last bit.
   task automatic drive_bits(input logic [1:0] r, input int len, input logic [31:0] data,
                             input bit gaps, input bit flip);
      int i = 0;
      bit took;
      bus.rate = r;
      for (int cyc = 0; cyc < 1000 && i < len; cyc++) begin
         bus.in_valid = !(gaps && ($urandom_range(0, 2) == 0));
         bus.in_bit   = data[len-1-i];
         bus.in_last  = (i == len - 1);
         if (flip && i > 0) bus.rate = r ^ 2'b10;
         @(negedge clk);
         took = bus.in_valid && bus.in_ready;
         @(posedge clk);
         #1;
         if (took) begin
            i++;
            if (i == len) last_taken = 1'b1;
         end
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_bit   = 1'b0;
      check("drive_complete", i, len);
   endtask

   task automatic monitor_out();
      for (int c = 0; c < 600 && !mon_done; c++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            got.push_back(bus.out_bit);
            if (bus.out_last) begin
               last_pos = got.size();
               mon_done = 1'b1;
            end
         end else if (bus.out_last) begin
            stray_last++;
         end
         if (!mon_done && last_taken && bus.in_ready) ready_bad++;
      end
   endtask

   task automatic run_burst(input vec_t v);
      logic [31:0] gp;
      int          first_bad;
      build_expected(v.rate, v.len, v.data);
      got.delete();
      last_pos   = -1;
      ready_bad  = 0;
      stray_last = 0;
      last_taken = 1'b0;
      mon_done   = 1'b0;
      fork
         drive_bits(v.rate, v.len, v.data, v.gaps, v.flip);
         monitor_out();
      join
      check({v.name, "_done"}, mon_done, 1);
      check({v.name, "_count"}, got.size(), v.exp_cnt);
      check({v.name, "_last_pos"}, last_pos, v.exp_cnt);
      check({v.name, "_stray_last"}, stray_last, 0);
      check({v.name, "_ready_in_tail"}, ready_bad, 0);
      if (v.plen > 0) begin
         gp = '0;
         for (int j = 0; j < v.plen; j++) begin
            gp = {gp[30:0], (j < got.size()) ? got[j] : 1'b0};
         end
         check({v.name, "_prefix"}, gp, v.prefix);
      end
      first_bad = -1;
      for (int j = 0; j < exp_q.size(); j++) begin
         if (first_bad < 0 && (j >= got.size() || got[j] != exp_q[j])) first_bad = j;
      end
      if (got.size() != exp_q.size() && first_bad < 0) first_bad = exp_q.size();
      check({v.name, "_stream_first_bad_idx"}, first_bad, -1);
      @(posedge clk);
      #1;
      check({v.name, "_enc_state_zero"}, dut.enc_state, 0);
      check({v.name, "_idle_ready"}, bus.in_ready, 1);
   endtask

   initial begin
      vecs[0] = '{"impulse_r12", 2'd0, 8, 32'h81, 32, 32,
                  32'b11101111000111_11101111000111_0000, 1'b0, 1'b0};
      vecs[1] = '{"r34_a53c", 2'd2, 16, 32'hA53C, 32, 0, 32'h0, 1'b0, 1'b0};
      vecs[2] = '{"r56_a53c", 2'd3, 16, 32'hA53C, 29, 0, 32'h0, 1'b0, 1'b1};
      vecs[3] = '{"r23_a53c", 2'd1, 16, 32'hA53C, 36, 0, 32'h0, 1'b0, 1'b1};
      vecs[4] = '{"single_r12", 2'd0, 1, 32'h1, 18, 18,
                  32'b111011110001110000, 1'b0, 1'b0};
      vecs[5] = '{"gaps_r12", 2'd0, 16, 32'hA53C, 48, 0, 32'h0, 1'b1, 1'b0};
      vecs[6] = '{"gaps_r34", 2'd2, 16, 32'hA53C, 32, 0, 32'h0, 1'b1, 1'b0};

      reset        = 1'b1;
      bus.in_bit   = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.rate     = 2'd0;
      #1;
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_out_bit", bus.out_bit, 0);
      check("reset_out_last", bus.out_last, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset_ready", bus.in_ready, 1);

      for (int k = 0; k < 7; k++) begin
         run_burst(vecs[k]);
      end

      // Reset while the zero tail is being injected.
      last_taken = 1'b0;
      drive_bits(2'd0, 8, 32'h81, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("mid_tail_active", bus.out_valid, 1);
      #1;
      reset = 1'b1;
      #1;
      check("mid_tail_rst_out_valid", bus.out_valid, 0);
      check("mid_tail_rst_out_bit", bus.out_bit, 0);
      check("mid_tail_rst_out_last", bus.out_last, 0);
      check("mid_tail_rst_ready", bus.in_ready, 1);
      check("mid_tail_rst_state", dut.enc_state, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      run_burst(vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
